// File: rtl/div_period_meter.sv
// Period meter for a divided clock: counts clk_in cycles between synchronized
// rising edges of sig_in, reports each period and tracks lock/overflow.
module div_period_meter #(
  parameter int W          = 16,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 0
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         en,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         locked,
  output logic         overflow,
  output logic [7:0]   edge_cnt
);

  localparam int MCW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [MCW-1:0] LOCK_V = MCW'(LOCK_COUNT);
  localparam logic [W:0]     TOL_V  = (W+1)'(TOL);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t         state, state_n;
  logic           s1, s2, s3;
  logic           rise;
  logic [W-1:0]   cnt, cnt_n;
  logic [W-1:0]   period_n;
  logic [MCW-1:0] match_cnt, match_cnt_n;
  logic           valid_n, locked_n, overflow_n;
  logic [7:0]     edge_cnt_n;
  logic [W:0]     diff;
  logic           match;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Magnitude difference kept one bit wider so it never wraps.
  always_comb begin
    if (cnt >= period) diff = {1'b0, cnt} - {1'b0, period};
    else               diff = {1'b0, period} - {1'b0, cnt};
    match = (diff <= TOL_V) && (period != '0);
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    period_n    = period;
    valid_n     = 1'b0;
    locked_n    = locked;
    overflow_n  = overflow;
    match_cnt_n = match_cnt;
    edge_cnt_n  = edge_cnt;
    if (!en) begin
      state_n     = IDLE;
      cnt_n       = '0;
      match_cnt_n = '0;
      locked_n    = 1'b0;
    end else begin
      if (rise) edge_cnt_n = edge_cnt + 8'd1;
      case (state)
        IDLE: begin
          cnt_n = '0;
          if (rise) begin
            cnt_n   = W'(1);
            state_n = MEASURE;
          end
        end
        MEASURE: begin
          // An edge arriving on the saturation cycle still counts as a period.
          if (rise) begin
            period_n   = cnt;
            valid_n    = 1'b1;
            cnt_n      = W'(1);
            overflow_n = 1'b0;
            if (match) begin
              match_cnt_n = (match_cnt == LOCK_V) ? LOCK_V : match_cnt + MCW'(1);
              locked_n    = (match_cnt_n == LOCK_V);
            end else begin
              match_cnt_n = MCW'(1);
              locked_n    = 1'b0;
            end
          end else if (cnt == '1) begin
            overflow_n  = 1'b1;
            locked_n    = 1'b0;
            match_cnt_n = '0;
            cnt_n       = '0;
            state_n     = IDLE;
          end else begin
            cnt_n = cnt + W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      overflow     <= 1'b0;
      match_cnt    <= '0;
      edge_cnt     <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      period       <= period_n;
      period_valid <= valid_n;
      locked       <= locked_n;
      overflow     <= overflow_n;
      match_cnt    <= match_cnt_n;
      edge_cnt     <= edge_cnt_n;
    end
  end

endmodule

// File: tb/tb_div_period_meter.sv
// Bench for div_period_meter: three configurations driven by generated divided
// clocks, compared every cycle against an edge-timestamp reference model.
module tb_div_period_meter;

  localparam int N    = 3;
  localparam int LOCK = 4;
  localparam int M_FIXED = 0, M_ALT = 1, M_RAND = 2, M_LOW = 3;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic sig_a = 1'b0, sig_b = 1'b0, sig_c = 1'b0;
  logic [15:0] period_a, period_b;
  logic [3:0]  period_c;
  logic pv_a, pv_b, pv_c, lk_a, lk_b, lk_c, ov_a, ov_b, ov_c;
  logic [7:0] ec_a, ec_b, ec_c;

  always #5 clk_in = ~clk_in;

  div_period_meter #(.W(16), .LOCK_COUNT(LOCK), .TOL(0)) u_a (
    .clk_in(clk_in), .rst(rst), .en(en_a), .sig_in(sig_a), .period(period_a),
    .period_valid(pv_a), .locked(lk_a), .overflow(ov_a), .edge_cnt(ec_a));
  div_period_meter #(.W(16), .LOCK_COUNT(LOCK), .TOL(1)) u_b (
    .clk_in(clk_in), .rst(rst), .en(en_b), .sig_in(sig_b), .period(period_b),
    .period_valid(pv_b), .locked(lk_b), .overflow(ov_b), .edge_cnt(ec_b));
  div_period_meter #(.W(4), .LOCK_COUNT(LOCK), .TOL(0)) u_c (
    .clk_in(clk_in), .rst(rst), .en(en_c), .sig_in(sig_c), .period(period_c),
    .period_valid(pv_c), .locked(lk_c), .overflow(ov_c), .edge_cnt(ec_c));

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: timestamps of synchronized rising edges, periods as differences.
  int w_of[N]   = '{16, 16, 4};
  int tol_of[N] = '{0, 1, 0};
  bit m_en[N];
  bit g_sig[N];
  bit smp[N][3];
  int now = 0;
  bit meas[N];
  int last_rise[N];
  int e_period[N], e_edges[N], streak[N];
  bit e_valid[N], e_locked[N], e_ovf[N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < 3; j++) smp[i][j] = 1'b0;
      meas[i] = 0; e_period[i] = 0; e_edges[i] = 0; streak[i] = 0;
      e_valid[i] = 0; e_locked[i] = 0; e_ovf[i] = 0;
    end
  endtask

  task automatic model_step();
    now++;
    for (int i = 0; i < N; i++) begin
      bit rise;
      int el;
      int d;
      bit m;
      rise = smp[i][1] && !smp[i][2];
      smp[i][2] = smp[i][1];
      smp[i][1] = smp[i][0];
      smp[i][0] = g_sig[i];
      e_valid[i] = 0;
      if (!m_en[i]) begin
        meas[i] = 0; streak[i] = 0; e_locked[i] = 0;
      end else begin
        if (rise) e_edges[i] = (e_edges[i] + 1) % 256;
        if (!meas[i]) begin
          if (rise) begin meas[i] = 1; last_rise[i] = now; end
        end else begin
          el = now - last_rise[i];
          if (rise) begin
            d = el - e_period[i];
            if (d < 0) d = -d;
            m = (e_period[i] != 0) && (d <= tol_of[i]);
            streak[i]   = m ? streak[i] + 1 : 1;
            e_locked[i] = m && (streak[i] >= LOCK);
            e_period[i] = el; e_valid[i] = 1; e_ovf[i] = 0; last_rise[i] = now;
          end else if (el == (1 << w_of[i]) - 1) begin
            e_ovf[i] = 1; e_locked[i] = 0; streak[i] = 0; meas[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic cmp_inst(input string nm, input int i, input logic [31:0] p,
                          input logic v, input logic l, input logic o, input logic [7:0] e);
    check({nm, ".period"},   p,       32'(e_period[i]));
    check({nm, ".valid"},    32'(v),  32'(e_valid[i]));
    check({nm, ".locked"},   32'(l),  32'(e_locked[i]));
    check({nm, ".overflow"}, 32'(o),  32'(e_ovf[i]));
    check({nm, ".edge_cnt"}, 32'(e),  32'(e_edges[i]));
  endtask

  task automatic check_all();
    cmp_inst("A", 0, 32'(period_a), pv_a, lk_a, ov_a, ec_a);
    cmp_inst("B", 1, 32'(period_b), pv_b, lk_b, ov_b, ec_b);
    cmp_inst("C", 2, 32'(period_c), pv_c, lk_c, ov_c, ec_c);
  endtask

  // Divided-clock generators: high for the first half of each period.
  int g_mode[N], g_base[N], g_cur[N], g_ph[N], g_rmax[N];
  bit g_alt[N];

  task automatic set_mode(input int i, input int mode, input int base);
    g_mode[i] = mode; g_base[i] = base;
    if (mode == M_LOW) g_ph[i] = 0;
  endtask

  task automatic gen_step_all();
    for (int i = 0; i < N; i++) begin
      if (g_mode[i] == M_LOW) begin
        g_sig[i] = 0; g_ph[i] = 0;
      end else begin
        if (g_ph[i] == 0) begin
          case (g_mode[i])
            M_FIXED: g_cur[i] = g_base[i];
            M_ALT: begin
              g_cur[i] = g_alt[i] ? g_base[i] + 1 : g_base[i];
              g_alt[i] = !g_alt[i];
            end
            default: g_cur[i] = int'($urandom_range(g_rmax[i], 2));
          endcase
        end
        g_sig[i] = (g_ph[i] < g_cur[i] / 2);
        g_ph[i]  = (g_ph[i] + 1 >= g_cur[i]) ? 0 : g_ph[i] + 1;
      end
    end
  endtask

  task automatic apply();
    sig_a = g_sig[0]; sig_b = g_sig[1]; sig_c = g_sig[2];
    en_a  = m_en[0];  en_b  = m_en[1];  en_c  = m_en[2];
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_step();
    #1;
    check_all();
    gen_step_all();
    apply();
  endtask

  initial begin
    bit found;
    model_reset();
    for (int i = 0; i < N; i++) m_en[i] = 1;
    g_rmax[0] = 12; g_rmax[1] = 9; g_rmax[2] = 20;
    set_mode(0, M_FIXED, 4);
    set_mode(1, M_ALT, 5);
    set_mode(2, M_FIXED, 5);
    apply();
    repeat (3) @(posedge clk_in);
    #1;
    check("rst.period_a", 32'(period_a), 0);
    check("rst.edge_cnt_c", 32'(ec_c), 0);
    check_all();
    rst = 1'b0;

    // Steady divide-by-4, alternating 5/6 within TOL=1, divide-by-5 on W=4.
    repeat (50) tick();
    check("A.lock4", 32'(lk_a), 1);
    check("A.per4", 32'(period_a), 4);
    check("B.lock56", 32'(lk_b), 1);
    check("C.per5", 32'(period_c), 5);

    // 4 -> 6 on A, 5/6 -> 8 on B, C stops toggling.
    set_mode(0, M_FIXED, 6);
    set_mode(1, M_FIXED, 8);
    set_mode(2, M_LOW, 0);
    repeat (20) tick();
    check("B.unlock8", 32'(lk_b), 0);
    check("B.per8", 32'(period_b), 8);
    repeat (10) tick();
    check("C.ovf", 32'(ov_c), 1);
    check("C.ovf_unlock", 32'(lk_c), 0);
    repeat (20) tick();
    check("A.lock6", 32'(lk_a), 1);
    check("A.per6", 32'(period_a), 6);

    // A enable dropped for 3 cycles; C restarts at period 7.
    m_en[0] = 0;
    set_mode(2, M_FIXED, 7);
    apply();
    tick();
    check("A.en_unlock", 32'(lk_a), 0);
    check("A.en_hold", 32'(period_a), 6);
    repeat (2) tick();
    m_en[0] = 1;
    apply();
    repeat (27) tick();
    check("C.ovf_clear", 32'(ov_c), 0);
    check("C.per7", 32'(period_c), 7);

    // Asynchronous reset between edges while A has counted to 3.
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      tick();
      if (meas[0] && (now - last_rise[0]) == 2) found = 1;
    end
    check("rst.find_cnt3", 32'(found), 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst.period_a", 32'(period_a), 0);
    check("arst.locked_a", 32'(lk_a), 0);
    check("arst.edge_a", 32'(ec_a), 0);
    check("arst.ovf_c", 32'(ov_c), 0);
    check_all();
    #1;
    rst = 1'b0;
    repeat (20) tick();

    // Random periods (C exceeds its 15-cycle range) with random enable toggles.
    for (int i = 0; i < N; i++) set_mode(i, M_RAND, 0);
    for (int c = 0; c < 300; c++) begin
      tick();
      if ($urandom_range(39, 0) == 0) begin
        int k;
        k = int'($urandom_range(2, 0));
        m_en[k] = !m_en[k];
        apply();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
